// File: rtl/rv32i_types_pkg.sv
// rtl/rv32i_types_pkg.sv - shared scalar functional-unit types for the dispatch slice
// Purpose: scalar_fu_t unit encoding, NUM_SFU and the dispatch holding-state type.
// Ports: none (package).
package rv32i_types_pkg;

  localparam int NUM_SFU = 4;

  typedef enum logic [1:0] {
    ARITH_S     = 2'd0,
    MUL_S       = 2'd1,
    DIV_S       = 2'd2,
    LOADSTORE_S = 2'd3
  } scalar_fu_t;

  typedef enum logic {
    EMPTY = 1'b0,
    HELD  = 1'b1
  } dispatch_state_t;

endpackage

// File: rtl/reg_scoreboard.sv
// rtl/reg_scoreboard.sv - 32-entry register busy scoreboard with x0 tied clear
// Purpose: tracks which architectural registers have a write outstanding.
// Ports:
//   CLK, nRST        clock, asynchronous active-low reset
//   set_en, set_idx  mark set_idx busy (issue of a writing instruction)
//   clr_en, clr_idx  mark clr_idx free (writeback)
//   busy             registered busy vector, bit 0 always 0
module reg_scoreboard (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        set_en,
  input  logic [4:0]  set_idx,
  input  logic        clr_en,
  input  logic [4:0]  clr_idx,
  output logic [31:0] busy
);

  // Only bits 31..1 are stored; x0 can never be busy.
  logic [31:1] busy_q;
  logic [31:0] set_mask;
  logic [31:0] clr_mask;
  logic [31:0] busy_d;

  assign busy = {busy_q, 1'b0};

  always_comb begin
    set_mask = set_en ? (32'd1 << set_idx) : 32'd0;
    clr_mask = clr_en ? (32'd1 << clr_idx) : 32'd0;
    // Clear first, then set: an issue and a writeback to the same register
    // in one cycle leaves the new write outstanding.
    busy_d   = (busy & ~clr_mask) | set_mask;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d[31:1];
    end
  end

endmodule

// File: rtl/scoreboard_dispatch.sv
// rtl/scoreboard_dispatch.sv - single-entry in-order dispatch with RAW/WAW/structural stall
// Purpose: holds one decoded instruction and issues it when its registers are
//   free in the scoreboard and its functional unit is not busy.
// Ports:
//   CLK, nRST                      clock, asynchronous active-low reset
//   dec_valid, dec_ready           decode handshake
//   sfu_type, reg_rs1/rs2/rd, wen  decoded instruction fields
//   fu_busy[NUM_SFU]               per-unit busy, indexed by scalar_fu_t
//   issue_valid, issue_fu          issue strobe and target unit
//   issue_rs1/rs2/rd, issue_wen    held instruction fields
//   wb_valid, wb_rd                writeback completion
//   flush                          discard the held instruction
//   stall_count                    (only with DISPATCH_STALL_COUNTER_EN) cycles held without issue
module scoreboard_dispatch
  import rv32i_types_pkg::*;
(
  input  logic               CLK,
  input  logic               nRST,
  input  logic               dec_valid,
  output logic               dec_ready,
  input  scalar_fu_t         sfu_type,
  input  logic [4:0]         reg_rs1,
  input  logic [4:0]         reg_rs2,
  input  logic [4:0]         reg_rd,
  input  logic               wen,
  input  logic [NUM_SFU-1:0] fu_busy,
  output logic               issue_valid,
  output scalar_fu_t         issue_fu,
  output logic [4:0]         issue_rs1,
  output logic [4:0]         issue_rs2,
  output logic [4:0]         issue_rd,
  output logic               issue_wen,
  input  logic               wb_valid,
  input  logic [4:0]         wb_rd,
  input  logic               flush
`ifdef DISPATCH_STALL_COUNTER_EN
  ,
  output logic [31:0]        stall_count
`endif
);

  dispatch_state_t state_q, state_d;
  scalar_fu_t      held_fu;
  logic [4:0]      held_rs1, held_rs2, held_rd;
  logic            held_wen;
  logic [31:0]     sb;
  logic            hazard;
  logic            accept;

  // Hazard uses the registered scoreboard only; a same-cycle writeback
  // releases the stall one cycle later.
  assign hazard = sb[held_rs1] | sb[held_rs2] | (held_wen & sb[held_rd]);
  assign accept = dec_valid & dec_ready;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (accept) begin
      state_d = HELD;
    end else if (issue_valid || flush) begin
      state_d = EMPTY;
    end
  end

  always_comb begin
    issue_valid = (state_q == HELD) & ~hazard & ~fu_busy[held_fu] & ~flush;
    dec_ready   = (state_q == EMPTY) | issue_valid | flush;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      held_fu  <= ARITH_S;
      held_rs1 <= '0;
      held_rs2 <= '0;
      held_rd  <= '0;
      held_wen <= 1'b0;
    end else if (accept) begin
      held_fu  <= sfu_type;
      held_rs1 <= reg_rs1;
      held_rs2 <= reg_rs2;
      held_rd  <= reg_rd;
      held_wen <= wen;
    end
  end

  assign issue_fu  = held_fu;
  assign issue_rs1 = held_rs1;
  assign issue_rs2 = held_rs2;
  assign issue_rd  = held_rd;
  assign issue_wen = held_wen;

  reg_scoreboard u_sb (
    .CLK     (CLK),
    .nRST    (nRST),
    .set_en  (issue_valid & held_wen & (held_rd != 5'd0)),
    .set_idx (held_rd),
    .clr_en  (wb_valid),
    .clr_idx (wb_rd),
    .busy    (sb)
  );

`ifdef DISPATCH_STALL_COUNTER_EN
  // Counts every held-but-not-issued cycle, including flush cycles; wraps.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stall_count <= '0;
    end else if ((state_q == HELD) && !issue_valid) begin
      stall_count <= stall_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_scoreboard_dispatch.sv
// tb/tb_scoreboard_dispatch.sv - directed table-driven bench for scoreboard_dispatch
module tb_scoreboard_dispatch;
  import rv32i_types_pkg::*;

  logic               CLK;
  logic               nRST;
  logic               dec_valid;
  logic               dec_ready;
  scalar_fu_t         sfu_type;
  logic [4:0]         reg_rs1, reg_rs2, reg_rd;
  logic               wen;
  logic [NUM_SFU-1:0] fu_busy;
  logic               issue_valid;
  scalar_fu_t         issue_fu;
  logic [4:0]         issue_rs1, issue_rs2, issue_rd;
  logic               issue_wen;
  logic               wb_valid;
  logic [4:0]         wb_rd;
  logic               flush;
`ifdef DISPATCH_STALL_COUNTER_EN
  logic [31:0]        stall_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  scoreboard_dispatch dut (
    .CLK         (CLK),
    .nRST        (nRST),
    .dec_valid   (dec_valid),
    .dec_ready   (dec_ready),
    .sfu_type    (sfu_type),
    .reg_rs1     (reg_rs1),
    .reg_rs2     (reg_rs2),
    .reg_rd      (reg_rd),
    .wen         (wen),
    .fu_busy     (fu_busy),
    .issue_valid (issue_valid),
    .issue_fu    (issue_fu),
    .issue_rs1   (issue_rs1),
    .issue_rs2   (issue_rs2),
    .issue_rd    (issue_rd),
    .issue_wen   (issue_wen),
    .wb_valid    (wb_valid),
    .wb_rd       (wb_rd),
    .flush       (flush)
`ifdef DISPATCH_STALL_COUNTER_EN
    ,
    .stall_count (stall_count)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic       dv;
    scalar_fu_t fu;
    logic [4:0] rs1, rs2, rd;
    logic       wen;
    logic [3:0] fub;
    logic       wbv;
    logic [4:0] wbrd;
    logic       fl;
    logic       e_rdy;
    logic       e_iv;
    logic       e_held;
    scalar_fu_t e_fu;
    logic [4:0] e_rd;
    logic [31:0] e_sb;
  } vec_t;

  vec_t vecs[12];

  function automatic vec_t mk(logic dv, scalar_fu_t fu, logic [4:0] rs1, logic [4:0] rs2,
                              logic [4:0] rd, logic w, logic [3:0] fub, logic wbv,
                              logic [4:0] wbrd, logic fl, logic e_rdy, logic e_iv,
                              logic e_held, scalar_fu_t e_fu, logic [4:0] e_rd,
                              logic [31:0] e_sb);
    vec_t v;
    v.dv = dv; v.fu = fu; v.rs1 = rs1; v.rs2 = rs2; v.rd = rd; v.wen = w;
    v.fub = fub; v.wbv = wbv; v.wbrd = wbrd; v.fl = fl;
    v.e_rdy = e_rdy; v.e_iv = e_iv; v.e_held = e_held; v.e_fu = e_fu;
    v.e_rd = e_rd; v.e_sb = e_sb;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic dv, input scalar_fu_t fu, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [4:0] rd, input logic w,
                       input logic [3:0] fub, input logic wbv, input logic [4:0] wbrd,
                       input logic fl);
    dec_valid = dv; sfu_type = fu; reg_rs1 = rs1; reg_rs2 = rs2; reg_rd = rd;
    wen = w; fu_busy = fub; wb_valid = wbv; wb_rd = wbrd; flush = fl;
  endtask

  task automatic idle();
    drive(1'b0, ARITH_S, 5'd0, 5'd0, 5'd0, 1'b0, 4'd0, 1'b0, 5'd0, 1'b0);
  endtask

  // Advance to the next cycle: inputs change just after the rising edge.
  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_cycle(input string tag, input logic e_rdy, input logic e_iv,
                             input logic [31:0] e_sb);
    @(negedge CLK);
    chk({tag, ".dec_ready"}, 32'(dec_ready), 32'(e_rdy));
    chk({tag, ".issue_valid"}, 32'(issue_valid), 32'(e_iv));
    chk({tag, ".sb"}, dut.sb, e_sb);
  endtask

  initial begin
    idle();
    nRST = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("reset.issue_valid", 32'(issue_valid), 32'd0);
    chk("reset.dec_ready", 32'(dec_ready), 32'd1);
    chk("reset.issue_fields", {issue_rs1, issue_rs2, issue_rd, issue_wen, issue_fu},
        32'd0);
    chk("reset.sb", dut.sb, 32'd0);
`ifdef DISPATCH_STALL_COUNTER_EN
    chk("reset.stall_count", stall_count, 32'd0);
`endif
    @(posedge CLK);
    #1 nRST = 1'b1;

    // Cycle-by-cycle vectors: basic issue, RAW stall with no wb bypass,
    // same-rd issue/wb collision, x0 destination and x0 sources.
    vecs[0]  = mk(1, ARITH_S,     1, 2, 3, 1, 4'b0000, 0, 0, 0, 1, 0, 0, ARITH_S,     0, 32'h0);
    vecs[1]  = mk(0, ARITH_S,     0, 0, 0, 0, 4'b1110, 0, 0, 0, 1, 1, 1, ARITH_S,     3, 32'h0);
    vecs[2]  = mk(1, ARITH_S,     3, 0, 4, 1, 4'b0000, 0, 0, 0, 1, 0, 0, ARITH_S,     0, 32'h8);
    vecs[3]  = mk(0, ARITH_S,     0, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 0, 1, ARITH_S,     4, 32'h8);
    vecs[4]  = mk(0, ARITH_S,     0, 0, 0, 0, 4'b0000, 1, 3, 0, 0, 0, 1, ARITH_S,     4, 32'h8);
    vecs[5]  = mk(0, ARITH_S,     0, 0, 0, 0, 4'b0000, 0, 0, 0, 1, 1, 1, ARITH_S,     4, 32'h0);
    vecs[6]  = mk(1, MUL_S,       0, 0, 7, 1, 4'b0000, 0, 0, 0, 1, 0, 0, ARITH_S,     0, 32'h10);
    vecs[7]  = mk(0, ARITH_S,     0, 0, 0, 0, 4'b0000, 1, 7, 0, 1, 1, 1, MUL_S,       7, 32'h10);
    vecs[8]  = mk(1, LOADSTORE_S, 0, 0, 0, 1, 4'b0000, 0, 0, 0, 1, 0, 0, ARITH_S,     0, 32'h90);
    vecs[9]  = mk(0, ARITH_S,     0, 0, 0, 0, 4'b0000, 1, 4, 0, 1, 1, 1, LOADSTORE_S, 0, 32'h90);
    vecs[10] = mk(0, ARITH_S,     0, 0, 0, 0, 4'b0000, 1, 7, 0, 1, 0, 0, ARITH_S,     0, 32'h80);
    vecs[11] = mk(0, ARITH_S,     0, 0, 0, 0, 4'b0000, 0, 0, 0, 1, 0, 0, ARITH_S,     0, 32'h0);

    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].dv, vecs[i].fu, vecs[i].rs1, vecs[i].rs2, vecs[i].rd, vecs[i].wen,
            vecs[i].fub, vecs[i].wbv, vecs[i].wbrd, vecs[i].fl);
      check_cycle($sformatf("vec%0d", i), vecs[i].e_rdy, vecs[i].e_iv, vecs[i].e_sb);
      if (vecs[i].e_held) begin
        chk($sformatf("vec%0d.issue_fu", i), 32'(issue_fu), 32'(vecs[i].e_fu));
        chk($sformatf("vec%0d.issue_rd", i), 32'(issue_rd), 32'(vecs[i].e_rd));
      end
      next_cycle();
    end

    // Fresh start so the stall counter begins at 0.
    nRST = 1'b0;
    next_cycle();
    nRST = 1'b1;

    // Structural stall: DIV held for 5 cycles behind a busy divider.
    drive(1, DIV_S, 1, 2, 5, 1, 4'b0100, 0, 0, 0);
    check_cycle("div.accept", 1'b1, 1'b0, 32'h0);
    next_cycle();
    for (int c = 0; c < 5; c++) begin
      drive(0, ARITH_S, 0, 0, 0, 0, 4'b0100, 0, 0, 0);
      check_cycle($sformatf("div.stall%0d", c), 1'b0, 1'b0, 32'h0);
      next_cycle();
    end
    idle();
    check_cycle("div.issue", 1'b1, 1'b1, 32'h0);
    chk("div.issue_fu", 32'(issue_fu), 32'(DIV_S));
`ifdef DISPATCH_STALL_COUNTER_EN
    chk("div.stall_count", stall_count, 32'd5);
`endif
    next_cycle();
    check_cycle("div.after", 1'b1, 1'b0, 32'h20);
`ifdef DISPATCH_STALL_COUNTER_EN
    chk("div.stall_count_hold", stall_count, 32'd5);
`endif

    // WAW stall on rd=5, then an asynchronous reset while it is held.
    drive(1, ARITH_S, 0, 0, 5, 1, 4'b0000, 0, 0, 0);
    next_cycle();
    idle();
    check_cycle("waw.stall", 1'b0, 1'b0, 32'h20);
    #2 nRST = 1'b0;
    #1;
    chk("midreset.issue_valid", 32'(issue_valid), 32'd0);
    chk("midreset.dec_ready", 32'(dec_ready), 32'd1);
    chk("midreset.issue_rd", 32'(issue_rd), 32'd0);
    chk("midreset.sb", dut.sb, 32'd0);
    next_cycle();
    nRST = 1'b1;
    drive(0, ARITH_S, 0, 0, 0, 0, 4'b0000, 1, 5, 0);
    check_cycle("late_wb", 1'b1, 1'b0, 32'h0);
    next_cycle();
    idle();
    check_cycle("late_wb.after", 1'b1, 1'b0, 32'h0);

    // Flush a stalled instruction while a new one is presented.
    drive(1, ARITH_S, 0, 0, 6, 1, 4'b0000, 0, 0, 0);
    next_cycle();
    idle();
    check_cycle("fl.first_issue", 1'b1, 1'b1, 32'h0);
    next_cycle();
    drive(1, ARITH_S, 6, 0, 8, 1, 4'b0000, 0, 0, 0);
    check_cycle("fl.load_old", 1'b1, 1'b0, 32'h40);
    next_cycle();
    idle();
    check_cycle("fl.old_stalled", 1'b0, 1'b0, 32'h40);
    chk("fl.old_rd", 32'(issue_rd), 32'd8);
    next_cycle();
    drive(1, MUL_S, 1, 2, 9, 1, 4'b0000, 0, 0, 1);
    check_cycle("fl.flush", 1'b1, 1'b0, 32'h40);
    next_cycle();
    idle();
    check_cycle("fl.new_issue", 1'b1, 1'b1, 32'h40);
    chk("fl.new_fu", 32'(issue_fu), 32'(MUL_S));
    chk("fl.new_rd", 32'(issue_rd), 32'd9);
    next_cycle();
    check_cycle("fl.after", 1'b1, 1'b0, 32'h240);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/scoreboard_dispatch.md
SCOREBOARD_DISPATCH -- requirements
Module: scoreboard_dispatch

Interface
REQ-001 SHALL have port CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port nRST, input, 1 bit: reset, asynchronous and active-low.
REQ-003 SHALL have port dec_valid, input, 1 bit: the control unit presents a decoded instruction.
REQ-004 SHALL have port dec_ready, output, 1 bit: the block accepts the decoded instruction this cycle.
REQ-005 SHALL have port sfu_type, input, scalar_fu_t (2 bits): target unit, one of ARITH_S, MUL_S, DIV_S, LOADSTORE_S.
REQ-006 SHALL have ports reg_rs1, reg_rs2 and reg_rd, input, 5 bits each, plus wen, input, 1 bit: register fields and the destination write enable.
REQ-007 SHALL have port fu_busy, input, 4 bits: per-unit busy flags, indexed by scalar_fu_t.
REQ-008 SHALL have ports issue_valid, output, 1 bit, and issue_fu, output, scalar_fu_t: the held instruction issues to issue_fu this cycle.
REQ-009 SHALL have ports issue_rs1, issue_rs2 and issue_rd, output, 5 bits each, plus issue_wen, output, 1 bit: the held instruction's fields.
REQ-010 SHALL have ports wb_valid, input, 1 bit, and wb_rd, input, 5 bits: a unit completes a write to wb_rd.
REQ-011 SHALL have port flush, input, 1 bit: discard the held instruction.

Function
REQ-012 SHALL hold at most one instruction, with state EMPTY or HELD.
REQ-013 SHALL assert dec_ready = (state==EMPTY) | issue_valid | flush.
REQ-014 SHALL capture the decode fields on dec_valid & dec_ready and go to HELD; otherwise it SHALL go to EMPTY after an issue or a flush.
REQ-015 SHALL keep a 32-bit busy scoreboard, sb, with bit 0 hard-wired to 0.
REQ-016 SHALL compute hazard = sb[rs1] | sb[rs2] | (wen & sb[rd]) from the registered sb; a wb in the same cycle SHALL NOT bypass it.
REQ-017 SHALL assert issue_valid = HELD & !hazard & !fu_busy[sfu] & !flush, combinationally, with zero added cycles when there is no hazard.
REQ-018 SHALL set sb[rd] on an issue with wen=1 and rd!=0.
REQ-019 SHALL clear sb[wb_rd] on wb_valid.
REQ-020 SHALL let the set win when an issue set and a wb clear hit the same rd in the same cycle.
REQ-021 SHALL, on flush with a simultaneous dec_valid, accept the new instruction into HELD and drop the old one; flush SHALL leave sb unchanged.
REQ-022 SHALL hold the issue_* outputs equal to the held fields whenever the state is HELD.

Reset
REQ-023 SHALL on nRST=0, asynchronously, set state=EMPTY, sb=0 and all held fields=0, giving issue_valid=0, dec_ready=1 and all issue_* outputs=0.
REQ-024 SHALL drop the held instruction when reset arrives mid-hold; in-flight writebacks after reset SHALL clear already-clear bits harmlessly.

Configuration
REQ-025 SHALL, with DISPATCH_STALL_COUNTER_EN defined, add output stall_count, 32 bits: it increments each cycle that state is HELD and issue_valid=0, wraps at 2^32-1 to 0, resets to 0 and ignores flush.
REQ-026 SHALL, without DISPATCH_STALL_COUNTER_EN, have neither the stall_count port nor the counter logic.

Structure
REQ-027 SHALL take scalar_fu_t and the FU count constant NUM_SFU=4 from rv32i_types_pkg, and SHALL declare no local copies.
REQ-028 SHALL place the scoreboard in one sub-module, reg_scoreboard, with ports set_en/set_idx, clr_en/clr_idx and a 32-bit busy vector; the dispatch logic stays in the top module.

Verification
REQ-029 SHALL check: reset, then dec_valid with ARITH_S, rs1=1, rs2=2, rd=3 -> issue_valid=1 the next cycle and sb[3]=1 one cycle later.
REQ-030 SHALL check a RAW stall: with sb[3]=1, present rs1=3 -> issue_valid=0 and dec_ready=0; wb_rd=3 -> issue_valid=1 one cycle after the wb.
REQ-031 SHALL check a structural stall: DIV_S held with fu_busy[DIV_S]=1 for 5 cycles -> no issue for those cycles and stall_count=5 (macro on); issue in the cycle fu_busy drops.
REQ-032 SHALL check the same-rd collision: issue rd=7 together with wb_valid, wb_rd=7 -> sb[7]=1 afterwards.
REQ-033 SHALL check x0: issue with rd=0 and wen=1 -> sb stays 0; rs1=0 never stalls.
REQ-034 SHALL check flush: flush with a stalled held instruction and dec_valid=1 -> the new instruction is HELD, the old one never issues, and sb is unchanged.
